// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Registered ALU with valid/ready handshakes. Logic, add, sub
//                and set-less-than finish in one cycle. Unsigned multiply
//                runs as a WIDTH-cycle shift-add loop.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_cmd,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_Res,
  output logic             o_zero,
  output logic             o_neg,
  output logic             o_carry,
  output logic             o_ovf
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] c_AND  = 3'b000;
  localparam logic [2:0] c_OR   = 3'b001;
  localparam logic [2:0] c_ADD  = 3'b010;
  localparam logic [2:0] c_MUL  = 3'b011;
  localparam logic [2:0] c_ANDN = 3'b100;
  localparam logic [2:0] c_ORN  = 3'b101;
  localparam logic [2:0] c_SUB  = 3'b110;
  localparam logic [2:0] c_SLT  = 3'b111;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               valid_q;
  logic [WIDTH-1:0]   res_q;
  logic               zero_q, neg_q, carry_q, ovf_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplr_q;
  logic [2*WIDTH-1:0] acc_q;

  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic               w_add_ovf;
  logic               w_sub_ovf;
  logic [WIDTH-1:0]   res_d;
  logic               carry_d;
  logic               ovf_d;
  logic [2*WIDTH-1:0] acc_d;
  logic               w_accept;

  assign o_ready  = i_rst_n & (state_q == S_IDLE) & (~valid_q | i_ready);
  assign w_accept = i_valid & o_ready;

  assign o_valid = valid_q;
  assign o_Res   = res_q;
  assign o_zero  = zero_q;
  assign o_neg   = neg_q;
  assign o_carry = carry_q;
  assign o_ovf   = ovf_q;

  // Single-cycle datapath; SUB is A + ~B + 1 so carry-out 1 means no borrow.
  always_comb begin
    w_add     = {1'b0, i_A} + {1'b0, i_B};
    w_sub     = {1'b0, i_A} + {1'b0, ~i_B} + (WIDTH+1)'(1);
    w_add_ovf = (i_A[WIDTH-1] == i_B[WIDTH-1]) & (w_add[WIDTH-1] != i_A[WIDTH-1]);
    w_sub_ovf = (i_A[WIDTH-1] != i_B[WIDTH-1]) & (w_sub[WIDTH-1] != i_A[WIDTH-1]);
    res_d     = '0;
    carry_d   = 1'b0;
    ovf_d     = 1'b0;
    case (i_cmd)
      c_AND:  res_d = i_A & i_B;
      c_OR:   res_d = i_A | i_B;
      c_ADD:  begin res_d = w_add[WIDTH-1:0]; carry_d = w_add[WIDTH]; ovf_d = w_add_ovf; end
      c_ANDN: res_d = i_A & ~i_B;
      c_ORN:  res_d = i_A | ~i_B;
      c_SUB:  begin res_d = w_sub[WIDTH-1:0]; carry_d = w_sub[WIDTH]; ovf_d = w_sub_ovf; end
      c_SLT:  res_d = {{(WIDTH-1){1'b0}}, w_sub[WIDTH-1] ^ w_sub_ovf};
      default: res_d = '0;
    endcase
  end

  // Accumulator value after this multiply step (used for the final write too).
  always_comb begin
    acc_d = acc_q + (mplr_q[0] ? mcand_q : '0);
  end

  // Control FSM, multiply iteration and registered result/flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            if (i_cmd == c_MUL) begin
              // Output is free or retiring here, so dropping valid is safe.
              mcand_q <= {{WIDTH{1'b0}}, i_A};
              mplr_q  <= i_B;
              acc_q   <= '0;
              cnt_q   <= '0;
              valid_q <= 1'b0;
              state_q <= S_MUL;
            end else begin
              res_q   <= res_d;
              zero_q  <= (res_d == '0);
              neg_q   <= res_d[WIDTH-1];
              carry_q <= carry_d;
              ovf_q   <= ovf_d;
              valid_q <= 1'b1;
            end
          end else if (valid_q && i_ready) begin
            valid_q <= 1'b0;
          end
        end
        S_MUL: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 1;
          mplr_q  <= mplr_q >> 1;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) begin
            res_q   <= acc_d[WIDTH-1:0];
            zero_q  <= (acc_d[WIDTH-1:0] == '0);
            neg_q   <= acc_d[WIDTH-1];
            carry_q <= 1'b0;
            ovf_q   <= |acc_d[2*WIDTH-1:WIDTH];
            valid_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu
//  Description : Directed self-checking bench for seq_alu (WIDTH = 32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_cmd;
  logic [31:0] i_A;
  logic [31:0] i_B;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_Res;
  logic        o_zero, o_neg, o_carry, o_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  seq_alu #(.WIDTH(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_cmd   (i_cmd),
    .i_A     (i_A),
    .i_B     (i_B),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_Res   (o_Res),
    .o_zero  (o_zero),
    .o_neg   (o_neg),
    .o_carry (o_carry),
    .o_ovf   (o_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] flags();
    return {o_zero, o_neg, o_carry, o_ovf};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request for a single edge; rdy is o_ready just before the edge.
  task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                       output logic rdy);
    @(negedge clk);
    i_cmd = c; i_A = a; i_B = b; i_valid = 1'b1;
    #1 rdy = o_ready;
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  // Single-cycle op: result must be visible right after the acceptance edge.
  task automatic op_chk(input string tag, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic [3:0] flg);
    logic rdy;
    issue(c, a, b, rdy);
    check({tag, "_rdy"}, 64'(rdy), 64'd1);
    check({tag, "_vld"}, 64'(o_valid), 64'd1);
    check({tag, "_res"}, 64'(o_Res), 64'(res));
    check({tag, "_flg"}, 64'(flags()), 64'(flg));
  endtask

  initial begin
    logic rdy;
    int   n;
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_cmd = 3'd0; i_A = '0; i_B = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", 64'(o_valid), 64'd0);
    check("rst_res", 64'(o_Res), 64'd0);
    check("rst_flg", 64'(flags()), 64'd0);
    check("rst_rdy", 64'(o_ready), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("rel_rdy", 64'(o_ready), 64'd1);

    // Logic ops and zero flag; flags = {zero,neg,carry,ovf}
    op_chk("and0", 3'b000, 32'd1, 32'd0, 32'd0, 4'b1000);
    op_chk("and1", 3'b000, 32'd1, 32'd1, 32'd1, 4'b0000);
    op_chk("or",   3'b001, 32'd0, 32'd1, 32'd1, 4'b0000);
    op_chk("andn", 3'b100, 32'd3, 32'd1, 32'd2, 4'b0000);
    op_chk("orn",  3'b101, 32'd0, 32'hFFFF_FFFE, 32'd1, 4'b0000);

    // ADD / SUB
    op_chk("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b0101);
    op_chk("add_cy",  3'b010, 32'hFFFF_FFFF, 32'd1, 32'd0,         4'b1010);
    op_chk("sub_pos", 3'b110, 32'd5, 32'd2, 32'd3,                 4'b0010);
    op_chk("sub_neg", 3'b110, 32'd2, 32'd5, 32'hFFFF_FFFD,         4'b0100);

    // SLT
    op_chk("slt_a", 3'b111, 32'd1, 32'd5, 32'd1, 4'b0000);
    op_chk("slt_b", 3'b111, 32'd5, 32'd1, 32'd0, 4'b1000);
    op_chk("slt_c", 3'b111, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0000);
    op_chk("slt_d", 3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 4'b0000);

    // MUL 7*6: result exactly 32 edges after acceptance, busy in between
    issue(3'b011, 32'd7, 32'd6, rdy);
    check("mul1_rdy", 64'(rdy), 64'd1);
    for (int i = 0; i < 32; i++) begin
      check("mul1_busy_vld", 64'(o_valid), 64'd0);
      check("mul1_busy_rdy", 64'(o_ready), 64'd0);
      @(posedge clk); #1;
    end
    check("mul1_vld", 64'(o_valid), 64'd1);
    check("mul1_res", 64'(o_Res), 64'd42);
    check("mul1_flg", 64'(flags()), 64'd0);

    // MUL 0x10000 * 0x10000: low word zero, upper word nonzero
    issue(3'b011, 32'h0001_0000, 32'h0001_0000, rdy);
    check("mul2_rdy", 64'(rdy), 64'd1);
    n = 0;
    while (!o_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("mul2_vld", 64'(o_valid), 64'd1);
    check("mul2_lat", 64'(n), 64'd32);
    check("mul2_res", 64'(o_Res), 64'd0);
    check("mul2_flg", 64'(flags()), 64'b1001);

    // Retire with no new request
    @(posedge clk); #1;
    check("retire_vld", 64'(o_valid), 64'd0);
    check("retire_res", 64'(o_Res), 64'd0);

    // Back-pressure: ADD 1+2 held while downstream stalls
    i_ready = 1'b0;
    op_chk("bp_first", 3'b010, 32'd1, 32'd2, 32'd3, 4'b0000);
    @(negedge clk);
    i_cmd = 3'b010; i_A = 32'd10; i_B = 32'd20; i_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold_rdy", 64'(o_ready), 64'd0);
      check("bp_hold_res", 64'(o_Res), 64'd3);
      check("bp_hold_vld", 64'(o_valid), 64'd1);
      @(negedge clk);
    end
    i_ready = 1'b1;
    #1 check("bp_release_rdy", 64'(o_ready), 64'd1);
    @(posedge clk); #1 i_valid = 1'b0;
    check("bp_second_vld", 64'(o_valid), 64'd1);
    check("bp_second_res", 64'(o_Res), 64'd30);

    // Back-to-back ADDs, one result per cycle
    for (int k = 1; k <= 4; k++) begin
      issue(3'b010, 32'(k), 32'(k * 16), rdy);
      check("b2b_rdy", 64'(rdy), 64'd1);
      check("b2b_vld", 64'(o_valid), 64'd1);
      check("b2b_res", 64'(o_Res), 64'(k * 17));
    end

    // Reset 10 cycles into a MUL
    op_chk("pre_rst", 3'b110, 32'd2, 32'd5, 32'hFFFF_FFFD, 4'b0100);
    issue(3'b011, 32'd3, 32'd5, rdy);
    check("mulr_rdy", 64'(rdy), 64'd1);
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1 check("mulr_rst_rdy", 64'(o_ready), 64'd0);
    @(posedge clk); #1;
    check("mulr_rst_vld", 64'(o_valid), 64'd0);
    check("mulr_rst_res", 64'(o_Res), 64'd0);
    check("mulr_rst_flg", 64'(flags()), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("mulr_rel_rdy", 64'(o_ready), 64'd1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      check("mulr_no_vld", 64'(o_valid), 64'd0);
    end
    op_chk("post_rst_add", 3'b010, 32'd2, 32'd2, 32'd4, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU with valid/ready handshakes and an iterative shift-add multiplier. It is the next-generation replacement for the combinational 32-bit `ALU` in the datapath: it keeps that block's 3-bit command encoding, adds status flags and multi-cycle operation, and is sized by `WIDTH`. It sits between the register-read stage and write-back, with back-pressure from downstream.

## Interface
- `WIDTH`, 32: operand and result width; legal values are 4 to 64.
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst_n`  in  1  reset: synchronous, active-low.
- `i_valid`  in  1  operand/command presented.
- `o_ready`  out  1  block can accept; transfer happens when `i_valid & o_ready` at the clock edge.
- `i_cmd`  in  3  operation select.
- `i_A`  in  WIDTH  operand A.
- `i_B`  in  WIDTH  operand B.
- `o_valid`  out  1  result valid; held until `i_ready`.
- `i_ready`  in  1  downstream accepts the result.
- `o_Res`  out  WIDTH  result.
- `o_zero`, `o_neg`, `o_carry`, `o_ovf`  out  1 each  result flags.

## Operation
- **Command encoding:**
  - 000 AND; 001 OR; 010 ADD.
  - 011 MUL: unsigned, low WIDTH bits, iterative.
  - 100 A AND ~B; 101 A OR ~B.
  - 110 SUB (A−B); 111 SLT (signed A<B gives 1, else 0).
- **States:**
  - IDLE: accepts single-cycle operations and MUL.
  - MUL: iterating.
- **Single-cycle operations:** computed from the captured operands. The result and flags load into the output registers at the acceptance edge. `o_valid` is set.
- **MUL accept:** A goes to the multiplicand register, which is 2·WIDTH bits wide and zero-extended. B goes to the multiplier register. The 2·WIDTH accumulator is cleared, the counter is set to 0, and the state becomes MUL.
- **Each MUL cycle:**
  - If multiplier[0] is 1, add the multiplicand to the accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1.
  - Increment the counter.
- **MUL completion:** on the cycle with counter = WIDTH−1, the final accumulation is written to `o_Res` as its low WIDTH bits. `o_valid` is set and the state returns to IDLE.
- **Flags:**
  - `o_zero` = (`o_Res` == 0).
  - `o_neg` = `o_Res`[WIDTH−1].
  - **ADD:** `o_carry` is the carry-out. `o_ovf` is signed overflow.
  - **SUB:** computed as A + ~B + 1. `o_carry` is the carry-out, so 1 means no borrow. `o_ovf` is signed overflow.
  - **SLT:** the result is (sign of A−B) XOR (overflow of A−B). `o_carry` and `o_ovf` are 0.
  - **MUL:** `o_carry` = 0. `o_ovf` = 1 when the upper WIDTH bits of the product are nonzero.
  - **Logic operations:** `o_carry` and `o_ovf` are 0.
- **Back-pressure:** while `o_valid & ~i_ready`, `o_Res` and all flags hold stable.
- **`o_ready`** (combinational) = `i_rst_n` & (state == IDLE) & (~`o_valid` | `i_ready`). This allows one result per cycle when downstream is ready.
- **Result retirement:** if `o_valid & i_ready` and there is no new acceptance, `o_valid` clears. `o_Res` and the flags retain their last value.
- **Unused-code rule:** none; all 8 codes are defined.

## Timing
- **Reset** (`i_rst_n` = 0 at an edge):
  - State goes to IDLE and the counter to 0.
  - `o_valid`, `o_Res`, and all four flags go to 0.
  - `o_ready` = 0 while `i_rst_n` is low. It is 1 in the first cycle after release.
- **Reset during MUL:** the multiply is aborted, with no result and no `o_valid`.
- **Latency, single-cycle operations:** `o_valid` is high 1 cycle after the acceptance edge.
- **Latency, MUL:** `o_valid` is high WIDTH cycles after the acceptance edge (32 for the default). `o_ready` = 0 during those cycles.
- **Throughput:** 1 operation per cycle for non-MUL operations. 1 MUL per WIDTH cycles.
- **Simultaneous retire and accept:** if `o_valid & i_ready` and a new single-cycle op is accepted in the same cycle, the new result replaces the old one and `o_valid` stays 1.
- **Same-cycle MUL accept:** a MUL accepted while the previous result is retired drops `o_valid` the next cycle.
- **MUL completion under back-pressure:** MUL completion never waits on `i_ready`. It is started only when the output is free or retiring, so it cannot overwrite an unaccepted result.
- **Inputs ignored:** `i_A`, `i_B` and `i_cmd` are ignored when `i_valid & o_ready` is not true.

## Test plan
- **Logic operations and zero flag** (WIDTH=32, `i_ready`=1):
  - cmd 000, A=1, B=0 → `o_Res`=0, `o_zero`=1.
  - cmd 000, A=1, B=1 → 1.
  - cmd 001, A=0, B=1 → 1.
  - cmd 100, A=3, B=1 → 2.
  - cmd 101, A=0, B=0xFFFFFFFE → 1.
  - All results appear 1 cycle after acceptance.
- **ADD/SUB flags:**
  - ADD 0x7FFFFFFF + 1 → 0x80000000, `o_ovf`=1, `o_neg`=1, `o_carry`=0.
  - ADD 0xFFFFFFFF + 1 → 0, `o_carry`=1, `o_zero`=1.
  - SUB 5 − 2 → 3, `o_carry`=1.
  - SUB 2 − 5 → 0xFFFFFFFD, `o_carry`=0, `o_neg`=1.
- **SLT:**
  - A=1, B=5 → 1.
  - A=5, B=1 → 0.
  - A=0xFFFFFFFF, B=1 → 1.
  - A=0x80000000, B=0x7FFFFFFF → 1, checking the case where the subtraction overflows.
- **MUL:**
  - A=7, B=6 → `o_Res`=42 exactly 32 cycles after acceptance, with `o_ready`=0 for the intervening cycles.
  - A=0x10000, B=0x10000 → `o_Res`=0, `o_zero`=1, `o_ovf`=1.
- **Back-pressure:**
  - Hold `i_ready`=0 and accept ADD 1+2. `o_Res`=3 is held for 5 cycles and `o_ready`=0 throughout; a second request is not accepted.
  - Raise `i_ready`: the second op is accepted that cycle and its result follows next cycle.
  - Also run back-to-back ADDs with `i_ready`=1 and check one result per cycle.
- **Reset mid-MUL:**
  - Assert `i_rst_n`=0 10 cycles into a MUL → all outputs are 0 on the next edge, and no `o_valid` appears afterward.
  - After release, `o_ready`=1 and a new ADD 2+2 returns 4.
